// File: rtl/retire_trace_pkg.sv
// Shared widths, default depth and pending-retire entry layout for the retire trace path.
package retire_trace_pkg;

  localparam int unsigned DEPTH_DEFAULT = 4;
  localparam int unsigned PC_W          = 32;
  localparam int unsigned IDX_W         = 5;
  localparam int unsigned DATA_W        = 32;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic              need_wb;
    logic              done;
    logic [IDX_W-1:0]  index;
    logic [DATA_W-1:0] data;
  } trace_entry_t;

endpackage

// File: rtl/retire_trace_fifo.sv
// In-order pending-retire storage; a deferred write completes the oldest entry still waiting for data.
module retire_trace_fifo
  import retire_trace_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              push,
  input  trace_entry_t      push_entry,
  input  logic              pop,
  input  logic              mark,
  input  logic [DATA_W-1:0] mark_data,
  output trace_entry_t      head,
  output logic              pend_hit,
  output logic [CNT_W-1:0]  count
);

  trace_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] mark_ptr;
  logic [PTR_W-1:0] scan_ptr;

  // Oldest occupied entry still waiting for its deferred write; head view includes a same-cycle mark.
  always_comb begin
    pend_hit = 1'b0;
    mark_ptr = rd_ptr;
    scan_ptr = rd_ptr;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      scan_ptr = rd_ptr + PTR_W'(i);
      if (!pend_hit && (CNT_W'(i) < count) &&
          mem[scan_ptr].need_wb && !mem[scan_ptr].done) begin
        pend_hit = 1'b1;
        mark_ptr = scan_ptr;
      end
    end
    head = mem[rd_ptr];
    if (mark && pend_hit && (mark_ptr == rd_ptr)) begin
      head.done = 1'b1;
      head.data = mark_data;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (mark && pend_hit) begin
        mem[mark_ptr].done <= 1'b1;
        mem[mark_ptr].data <= mark_data;
      end
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/retire_trace_tx.sv
// Retire trace transmitter: builds entries from retires, bypasses when idle, emits in order to the pads.
module retire_trace_tx
  import retire_trace_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              rtu_retire_vld,
  input  logic [PC_W-1:0]   rtu_retire_pc,
  input  logic              rtu_wb_en,
  input  logic [IDX_W-1:0]  rtu_wb_index,
  input  logic [DATA_W-1:0] rtu_wb_data,
  input  logic              rtu_wb_pend,
  input  logic              lsu_wb_en,
  input  logic [DATA_W-1:0] lsu_wb_data,
  output logic              biu_pad_retire,
  output logic [PC_W-1:0]   biu_pad_retire_pc,
  output logic              biu_pad_wb_gpr_en,
  output logic [IDX_W-1:0]  biu_pad_wb_gpr_index,
  output logic [DATA_W-1:0] biu_pad_wb_gpr_data,
  output logic              trace_full,
  output logic              trace_ovf,
  output logic              trace_err
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  trace_entry_t      in_entry;
  trace_entry_t      head;
  trace_entry_t      emit_entry;
  logic [CNT_W-1:0]  count;
  logic              pend_hit;
  logic              in_need;
  logic              in_pend;
  logic              lsu_to_in;
  logic              lsu_err;
  logic              fifo_empty;
  logic              pop;
  logic              push;
  logic              bypass;
  logic              emit;
  logic              drop;
  logic              wb_stage_vld;
  logic [IDX_W-1:0]  wb_stage_index;
  logic [DATA_W-1:0] wb_stage_data;

  assign trace_full = (count == CNT_W'(DEPTH));

  // A deferred write goes to the FIFO if anything there waits, else to a pending retire arriving now.
  always_comb begin
    in_need   = (rtu_wb_en || rtu_wb_pend) && (rtu_wb_index != '0);
    in_pend   = rtu_wb_pend && in_need;
    lsu_to_in = lsu_wb_en && !pend_hit && rtu_retire_vld && in_pend;
    lsu_err   = lsu_wb_en && !pend_hit && !lsu_to_in;

    in_entry.pc      = rtu_retire_pc;
    in_entry.need_wb = in_need;
    in_entry.done    = !in_pend || lsu_to_in;
    in_entry.index   = rtu_wb_index;
    in_entry.data    = lsu_to_in ? lsu_wb_data : rtu_wb_data;

    fifo_empty = (count == '0);
    pop        = !fifo_empty && head.done;
    bypass     = fifo_empty && rtu_retire_vld && in_entry.done;
    emit       = pop || bypass;
    emit_entry = pop ? head : in_entry;
    push       = rtu_retire_vld && !bypass && (!trace_full || pop);
    drop       = rtu_retire_vld && !bypass && trace_full && !pop;
  end

  retire_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_b      (rst_b),
    .push       (push),
    .push_entry (in_entry),
    .pop        (pop),
    .mark       (lsu_wb_en),
    .mark_data  (lsu_wb_data),
    .head       (head),
    .pend_hit   (pend_hit),
    .count      (count)
  );

  // Retire pulse one cycle after emit; the GPR write trails it by one more through an internal stage.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      biu_pad_retire       <= 1'b0;
      biu_pad_retire_pc    <= '0;
      biu_pad_wb_gpr_en    <= 1'b0;
      biu_pad_wb_gpr_index <= '0;
      biu_pad_wb_gpr_data  <= '0;
      wb_stage_vld         <= 1'b0;
      wb_stage_index       <= '0;
      wb_stage_data        <= '0;
      trace_ovf            <= 1'b0;
      trace_err            <= 1'b0;
    end else begin
      biu_pad_retire <= emit;
      if (emit) begin
        biu_pad_retire_pc <= emit_entry.pc;
      end
      wb_stage_vld <= emit && emit_entry.need_wb;
      if (emit && emit_entry.need_wb) begin
        wb_stage_index <= emit_entry.index;
        wb_stage_data  <= emit_entry.data;
      end
      biu_pad_wb_gpr_en <= wb_stage_vld;
      if (wb_stage_vld) begin
        biu_pad_wb_gpr_index <= wb_stage_index;
        biu_pad_wb_gpr_data  <= wb_stage_data;
      end
      if (drop) begin
        trace_ovf <= 1'b1;
      end
      if (lsu_err) begin
        trace_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_retire_trace_tx.sv
// Bench for retire_trace_tx: directed scenarios plus random traffic against a queue-based reference model.
module tb_retire_trace_tx;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        rtu_retire_vld;
  logic [31:0] rtu_retire_pc;
  logic        rtu_wb_en;
  logic [4:0]  rtu_wb_index;
  logic [31:0] rtu_wb_data;
  logic        rtu_wb_pend;
  logic        lsu_wb_en;
  logic [31:0] lsu_wb_data;
  logic        biu_pad_retire;
  logic [31:0] biu_pad_retire_pc;
  logic        biu_pad_wb_gpr_en;
  logic [4:0]  biu_pad_wb_gpr_index;
  logic [31:0] biu_pad_wb_gpr_data;
  logic        trace_full;
  logic        trace_ovf;
  logic        trace_err;

  retire_trace_tx #(.DEPTH(DEPTH)) dut (
    .clk                  (clk),
    .rst_b                (rst_b),
    .rtu_retire_vld       (rtu_retire_vld),
    .rtu_retire_pc        (rtu_retire_pc),
    .rtu_wb_en            (rtu_wb_en),
    .rtu_wb_index         (rtu_wb_index),
    .rtu_wb_data          (rtu_wb_data),
    .rtu_wb_pend          (rtu_wb_pend),
    .lsu_wb_en            (lsu_wb_en),
    .lsu_wb_data          (lsu_wb_data),
    .biu_pad_retire       (biu_pad_retire),
    .biu_pad_retire_pc    (biu_pad_retire_pc),
    .biu_pad_wb_gpr_en    (biu_pad_wb_gpr_en),
    .biu_pad_wb_gpr_index (biu_pad_wb_gpr_index),
    .biu_pad_wb_gpr_data  (biu_pad_wb_gpr_data),
    .trace_full           (trace_full),
    .trace_ovf            (trace_ovf),
    .trace_err            (trace_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    bit          need;
    bit          done;
    logic [4:0]  idx;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  int          n_pass = 0;
  int          n_fail = 0;
  int          n_total = 0;
  bit          m_ret, m_wb, m_full, m_ovf, m_err;
  logic [31:0] m_pc, m_data;
  logic [4:0]  m_idx;
  bit          nx_wb;
  logic [4:0]  nx_idx;
  logic [31:0] nx_data;
  bit          log_on;
  logic [4:0]  isa_idx[$];
  logic [31:0] isa_data[$];
  int          isa_pend[$];
  logic [4:0]  pad_idx[$];
  logic [31:0] pad_data[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rtu_retire_vld = 1'b0;
    rtu_retire_pc  = '0;
    rtu_wb_en      = 1'b0;
    rtu_wb_index   = '0;
    rtu_wb_data    = '0;
    rtu_wb_pend    = 1'b0;
    lsu_wb_en      = 1'b0;
    lsu_wb_data    = '0;
  endtask

  task automatic retire(input logic [31:0] pc, input bit load, input logic [4:0] idx,
                        input logic [31:0] data);
    rtu_retire_vld = 1'b1;
    rtu_retire_pc  = pc;
    rtu_wb_en      = !load;
    rtu_wb_pend    = load;
    rtu_wb_index   = idx;
    rtu_wb_data    = data;
  endtask

  task automatic model_reset();
    q.delete();
    m_ret = 0; m_wb = 0; m_full = 0; m_ovf = 0; m_err = 0;
    m_pc = '0; m_idx = '0; m_data = '0;
    nx_wb = 0; nx_idx = '0; nx_data = '0;
  endtask

  // Reference: queue of retired-but-untraced instructions, evaluated on this cycle's inputs.
  task automatic model_eval();
    ent_t inc, em;
    int   sz0;
    bit   found, emitted, bypassed, popped, accepted;
    inc.pc   = rtu_retire_pc;
    inc.need = (rtu_wb_en || rtu_wb_pend) && (rtu_wb_index != 5'd0);
    inc.done = !(rtu_wb_pend && inc.need);
    inc.idx  = rtu_wb_index;
    inc.data = rtu_wb_data;
    sz0 = q.size();
    found = 0;
    if (lsu_wb_en) begin
      for (int i = 0; i < q.size(); i++) begin
        if (!found && q[i].need && !q[i].done) begin
          q[i].done = 1; q[i].data = lsu_wb_data; found = 1;
        end
      end
      if (!found && rtu_retire_vld && !inc.done) begin
        inc.done = 1; inc.data = lsu_wb_data; found = 1;
      end
      if (!found) m_err = 1;
    end
    emitted = 0; popped = 0; bypassed = 0; accepted = 0; em = inc;
    if (sz0 > 0) begin
      if (q[0].done) begin em = q.pop_front(); emitted = 1; popped = 1; end
    end else if (rtu_retire_vld && inc.done) begin
      emitted = 1; bypassed = 1; accepted = 1;
    end
    if (rtu_retire_vld && !bypassed) begin
      if (sz0 < int'(DEPTH) || popped) begin q.push_back(inc); accepted = 1; end
      else m_ovf = 1;
    end
    m_wb = nx_wb;
    if (nx_wb) begin m_idx = nx_idx; m_data = nx_data; end
    nx_wb = emitted && em.need;
    if (nx_wb) begin nx_idx = em.idx; nx_data = em.data; end
    m_ret = emitted;
    if (emitted) m_pc = em.pc;
    m_full = (q.size() == int'(DEPTH));
    // Architectural GPR write log in program order; load data filled in as it arrives.
    if (log_on) begin
      if (accepted && inc.need) begin
        isa_idx.push_back(rtu_wb_index);
        if (rtu_wb_pend) begin
          isa_data.push_back('0);
          isa_pend.push_back(isa_idx.size() - 1);
        end else begin
          isa_data.push_back(rtu_wb_data);
        end
      end
      if (lsu_wb_en && isa_pend.size() > 0) begin
        int pos;
        pos = isa_pend.pop_front();
        isa_data[pos] = lsu_wb_data;
      end
    end
  endtask

  task automatic check_outputs();
    chk("retire",  32'(biu_pad_retire),       32'(m_ret));
    chk("pc",      biu_pad_retire_pc,         m_pc);
    chk("wb_en",   32'(biu_pad_wb_gpr_en),    32'(m_wb));
    chk("wb_idx",  32'(biu_pad_wb_gpr_index), 32'(m_idx));
    chk("wb_data", biu_pad_wb_gpr_data,       m_data);
    chk("full",    32'(trace_full),           32'(m_full));
    chk("ovf",     32'(trace_ovf),            32'(m_ovf));
    chk("err",     32'(trace_err),            32'(m_err));
  endtask

  task automatic step();
    model_eval();
    @(posedge clk);
    #1;
    check_outputs();
    if (log_on && biu_pad_wb_gpr_en) begin
      pad_idx.push_back(biu_pad_wb_gpr_index);
      pad_data.push_back(biu_pad_wb_gpr_data);
    end
    idle();
  endtask

  task automatic do_reset();
    idle();
    rst_b = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    rst_b = 1'b1;
  endtask

  initial begin
    log_on = 0;
    idle();
    rst_b = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst_b = 1'b1;

    // ALU retire with immediate write
    retire(32'h100, 0, 5'd5, 32'hA5A5_A5A5); step();
    chk("alu_retire", 32'(biu_pad_retire), 32'd1);
    chk("alu_pc", biu_pad_retire_pc, 32'h100);
    step();
    chk("alu_wb_en", 32'(biu_pad_wb_gpr_en), 32'd1);
    chk("alu_wb_idx", 32'(biu_pad_wb_gpr_index), 32'd5);
    chk("alu_wb_data", biu_pad_wb_gpr_data, 32'hA5A5_A5A5);
    step();

    // Load then ALU; load data arrives four cycles after the load retires
    retire(32'h200, 1, 5'd7, 32'h0); step();
    retire(32'h204, 0, 5'd8, 32'h88); step();
    step(); step();
    lsu_wb_en = 1'b1; lsu_wb_data = 32'h11; step();
    chk("ld_retire_pc", biu_pad_retire_pc, 32'h200);
    chk("ld_retire", 32'(biu_pad_retire), 32'd1);
    step();
    chk("ld_wb_idx", 32'(biu_pad_wb_gpr_index), 32'd7);
    chk("ld_wb_data", biu_pad_wb_gpr_data, 32'h11);
    chk("alu2_pc", biu_pad_retire_pc, 32'h204);
    step();
    chk("alu2_wb_idx", 32'(biu_pad_wb_gpr_index), 32'd8);
    step();

    // Fill with pending loads, then one retire too many
    for (int i = 0; i < 4; i++) begin
      retire(32'h400 + 32'(4 * i), 1, 5'(i + 1), 32'h0); step();
    end
    chk("fill_full", 32'(trace_full), 32'd1);
    retire(32'h410, 0, 5'd9, 32'h99); step();
    chk("fill_ovf", 32'(trace_ovf), 32'd1);
    for (int i = 0; i < 4; i++) begin
      lsu_wb_en = 1'b1; lsu_wb_data = 32'h1000 + 32'(i); step();
    end
    repeat (3) step();

    // Write to x0 and an orphan deferred write
    retire(32'h500, 0, 5'd0, 32'hFFFF_FFFF); step();
    chk("x0_retire", 32'(biu_pad_retire), 32'd1);
    step();
    chk("x0_wb_en", 32'(biu_pad_wb_gpr_en), 32'd0);
    lsu_wb_en = 1'b1; lsu_wb_data = 32'hDEAD; step();
    chk("orphan_err", 32'(trace_err), 32'd1);
    chk("orphan_retire", 32'(biu_pad_retire), 32'd0);
    step();

    // Reset with three pending entries
    for (int i = 0; i < 3; i++) begin
      retire(32'h600 + 32'(4 * i), 1, 5'(i + 10), 32'h0); step();
    end
    do_reset();
    retire(32'h300, 0, 5'd3, 32'h33); step();
    chk("post_rst_retire", 32'(biu_pad_retire), 32'd1);
    chk("post_rst_pc", biu_pad_retire_pc, 32'h300);
    step(); step();

    // Random traffic with the GPR log monitor enabled
    do_reset();
    isa_idx.delete(); isa_data.delete(); isa_pend.delete();
    pad_idx.delete(); pad_data.delete();
    log_on = 1;
    for (int c = 0; c < 400; c++) begin
      bit want_lsu;
      if (!m_full && ($urandom_range(0, 9) < 6)) begin
        retire($urandom & 32'hFFFF_FFFC, ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 31)),
               $urandom);
        if (!rtu_wb_pend && ($urandom_range(0, 4) == 0)) rtu_wb_en = 1'b0;
      end
      want_lsu = (isa_pend.size() > 0) ||
                 (rtu_retire_vld && rtu_wb_pend && rtu_wb_index != 5'd0);
      if (want_lsu && ($urandom_range(0, 2) == 0)) begin
        lsu_wb_en = 1'b1; lsu_wb_data = $urandom;
      end
      step();
    end
    for (int c = 0; c < 64 && isa_pend.size() > 0; c++) begin
      lsu_wb_en = 1'b1; lsu_wb_data = $urandom; step();
    end
    repeat (DEPTH + 4) step();
    log_on = 0;

    chk("log_len", 32'(pad_idx.size()), 32'(isa_idx.size()));
    for (int i = 0; i < isa_idx.size() && i < pad_idx.size(); i++) begin
      chk("log_idx", 32'(pad_idx[i]), 32'(isa_idx[i]));
      chk("log_data", pad_data[i], isa_data[i]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/retire_trace_tx.md
RETIRE_TRACE_TX -- requirements
Module: retire_trace_tx

Interface
REQ-001 Parameter DEPTH, default 4, is the number of pending-retire entries (power of two, 2..16).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_b  input  1  asynchronous, active-low reset.
REQ-004 rtu_retire_vld  input  1  one instruction retires this cycle.
REQ-005 rtu_retire_pc  input  32  PC of the retiring instruction.
REQ-006 rtu_wb_en / rtu_wb_index / rtu_wb_data  input  1/5/32  GPR write completed in the same cycle as the retire.
REQ-007 rtu_wb_pend  input  1  the retiring instruction's GPR write arrives later (load); rtu_wb_index gives its destination.
REQ-008 lsu_wb_en / lsu_wb_data  input  1/32  deferred GPR write data; deferred writes arrive in retire order.
REQ-009 biu_pad_retire  output  1  trace retire pulse.
REQ-010 biu_pad_retire_pc  output  32  trace retire PC.
REQ-011 biu_pad_wb_gpr_en / biu_pad_wb_gpr_index / biu_pad_wb_gpr_data  output  1/5/32  trace GPR write.
REQ-012 trace_full  output  1  entry count equals DEPTH; the core stalls retire while this is high.
REQ-013 trace_ovf / trace_err  output  1/1  sticky error flags: retire dropped, and deferred write with no pending entry.

Function
REQ-014 Each accepted retire creates an entry {pc, need_wb, done, index, data}:
- need_wb = (rtu_wb_en or rtu_wb_pend) and index != 0.
- done = 1 unless rtu_wb_pend and need_wb.
REQ-015 Entries are emitted strictly in retire order, at most one per cycle, and only when the head entry is done.
REQ-016 Emitting an entry in cycle N:
- biu_pad_retire = 1 and biu_pad_retire_pc = pc in cycle N+1, registered.
- If need_wb, biu_pad_wb_gpr_en/index/data are driven in cycle N+2, exactly one cycle after the retire pulse.
REQ-017 All outputs are registered; biu_pad_wb_gpr_en and biu_pad_retire are 1-cycle pulses, and the data/PC fields hold their last values otherwise.
REQ-018 Bypass: with the FIFO empty and an incoming entry done, the entry is emitted in the same cycle (retire-to-pad latency 1).
REQ-019 A wb pulse for entry k and the retire pulse for entry k+1 may coincide in the same cycle.
REQ-020 lsu_wb_en completes the oldest entry with need_wb=1 and done=0, including an entry arriving in the same cycle; that entry may be emitted in the same cycle.
REQ-021 lsu_wb_en with no such entry sets trace_err and the data is discarded.
REQ-022 A push and a pop in the same cycle are both performed, and the count is unchanged.
REQ-023 A push while full without a pop in the same cycle is dropped and sets trace_ovf.
REQ-024 trace_full is combinational from the registered count.
REQ-025 Writes to x0 (from either wb source) never assert biu_pad_wb_gpr_en.
REQ-026 Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH; the count is log2(DEPTH)+1 bits.

Reset
REQ-027 While rst_b is low, all of the following are 0: every output, all pointers, the count, all entry done/need_wb bits, and the sticky flags.
REQ-028 Reset mid-operation discards pending entries with no trace output; the first retire after release behaves as from an empty FIFO.

Structure
REQ-029 Package retire_trace_pkg holds the entry struct typedef, the default DEPTH, and the PC/index/data width constants.
REQ-030 Entry storage and pointers live in sub-module retire_trace_fifo, which also provides a "mark oldest pending done" port.
REQ-031 retire_trace_tx holds the bypass, emit control and output registers.

Verification
REQ-032 Directed scenarios the bench shall cover:
- ALU retire: pc 0x100, wb x5 = 0xA5A5A5A5 at cycle T -> retire/pc 0x100 at T+1; wb en, idx 5, data 0xA5A5A5A5 at T+2.
- Load then ALU: load pc 0x200 pend x7 at T, ALU pc 0x204 wb x8 at T+1, lsu data 0x11 at T+4 -> retire 0x200 at T+5, wb x7=0x11 at T+6 together with retire 0x204, then wb x8 at T+7.
- Fill: 4 pending loads plus a 5th retire without a pop -> trace_full high after the 4th; 5th dropped, trace_ovf = 1; no trace output for the dropped entry.
- Corner cases: wb to x0 -> retire pulse only, biu_pad_wb_gpr_en stays 0; lsu_wb_en on an empty FIFO -> trace_err = 1, no output.
- Reset with 3 pending entries -> all outputs 0; next retire pc 0x300 appears 1 cycle later.
- Feed the pad outputs to the GPR log monitor and compare its log line-for-line against the instruction-set model.
